// File: rtl/fpmul_rr_arbiter_pkg.sv
// Shared types for the FPmul round-robin front end: widths, latency default,
// the in-flight tag record and the grant selection rule.
package fpmul_rr_arbiter_pkg;

  localparam int FP_W        = 32;
  localparam int MUL_LAT_DEF = 4;
  localparam int REQ_ID_W    = 1;

  typedef logic [REQ_ID_W-1:0] req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

  // One tag travels alongside each operand pair through FPmul.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  localparam tag_t TAG_NONE = '{valid: 1'b0, id: REQ0};

  // Round-robin choice: a lone requester always wins; on contention the
  // requester that did not win last time goes next.
  function automatic tag_t pick_grant(input logic v0, input logic v1, input req_id_t last);
    tag_t g;
    g = TAG_NONE;
    if (v0 && v1) begin
      g.valid = 1'b1;
      g.id    = (last == REQ0) ? REQ1 : REQ0;
    end else if (v0) begin
      g.valid = 1'b1;
      g.id    = REQ0;
    end else if (v1) begin
      g.valid = 1'b1;
      g.id    = REQ1;
    end
    return g;
  endfunction

endpackage

// File: rtl/fpmul_rr_arbiter_if.sv
// Bundle of requester handshakes, result pulses and the FPmul operand/result bus.
// Handshake: a transfer occurs at a rising edge where reqN_valid && reqN_ready;
// a/b must stay stable while valid is high and ready is low; results are
// one-cycle pulses with no backpressure.
interface fpmul_rr_arbiter_if import fpmul_rr_arbiter_pkg::*; ();

  logic            req0_valid;
  logic            req0_ready;
  logic [FP_W-1:0] req0_a;
  logic [FP_W-1:0] req0_b;
  logic            req1_valid;
  logic            req1_ready;
  logic [FP_W-1:0] req1_a;
  logic [FP_W-1:0] req1_b;
  logic            res0_valid;
  logic [FP_W-1:0] res0_z;
  logic            res1_valid;
  logic [FP_W-1:0] res1_z;
  logic [FP_W-1:0] FP_A;
  logic [FP_W-1:0] FP_B;
  logic [FP_W-1:0] FP_Z;
  logic            busy;

  // Client/FPmul side.
  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output FP_Z,
    input  req0_ready, req1_ready,
    input  res0_valid, res0_z, res1_valid, res1_z,
    input  FP_A, FP_B, busy
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  FP_Z,
    output req0_ready, req1_ready,
    output res0_valid, res0_z, res1_valid, res1_z,
    output FP_A, FP_B, busy
  );

endinterface

// File: rtl/fpmul_rr_arbiter_tag_pipe.sv
// Fixed-depth shift register of tags that mirrors FPmul's pipeline so each
// tag leaves exactly when its product appears on FP_Z.
module fpmul_rr_arbiter_tag_pipe
  import fpmul_rr_arbiter_pkg::*;
#(
  parameter int DEPTH = MUL_LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out,
  output logic any_valid
);

  tag_t stages [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= TAG_NONE;
    end else begin
      stages[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_valid = any_valid | stages[i].valid;
  end

  assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/fpmul_rr_arbiter.sv
// Two-requester round-robin front end for one shared, stall-free FPmul:
// grants one operand pair per cycle and steers each product back by tag.
module fpmul_rr_arbiter
  import fpmul_rr_arbiter_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  fpmul_rr_arbiter_if.slave    bus
);

  req_id_t last_grant;
  tag_t    grant;
  tag_t    issue_tag;
  tag_t    pipe_out;
  logic    pipe_busy;

  // Nothing is granted while reset is held, so no transfer can slip in.
  always_comb begin
    grant = pick_grant(bus.req0_valid, bus.req1_valid, last_grant);
    if (rst) grant = TAG_NONE;
  end

  assign bus.req0_ready = grant.valid && (grant.id == REQ0);
  assign bus.req1_ready = grant.valid && (grant.id == REQ1);

  // issue_tag rides with FP_A/FP_B; the pipe then covers FPmul's MUL_LAT stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.FP_A   <= '0;
      bus.FP_B   <= '0;
      last_grant <= REQ1;
      issue_tag  <= TAG_NONE;
    end else begin
      issue_tag <= grant;
      if (grant.valid) begin
        last_grant <= grant.id;
        bus.FP_A   <= (grant.id == REQ1) ? bus.req1_a : bus.req0_a;
        bus.FP_B   <= (grant.id == REQ1) ? bus.req1_b : bus.req0_b;
      end
    end
  end

  fpmul_rr_arbiter_tag_pipe #(
    .DEPTH (MUL_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .tag_in    (issue_tag),
    .tag_out   (pipe_out),
    .any_valid (pipe_busy)
  );

  // Result demux: the unaddressed requester keeps its last product.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.res0_valid <= 1'b0;
      bus.res1_valid <= 1'b0;
      bus.res0_z     <= '0;
      bus.res1_z     <= '0;
    end else begin
      bus.res0_valid <= pipe_out.valid && (pipe_out.id == REQ0);
      bus.res1_valid <= pipe_out.valid && (pipe_out.id == REQ1);
      if (pipe_out.valid && (pipe_out.id == REQ0)) bus.res0_z <= bus.FP_Z;
      if (pipe_out.valid && (pipe_out.id == REQ1)) bus.res1_z <= bus.FP_Z;
    end
  end

  assign bus.busy = issue_tag.valid | pipe_busy;

endmodule

// File: tb/tb_fpmul_rr_arbiter.sv
// Directed bench for fpmul_rr_arbiter with a stand-in FPmul (latency pipe over
// a table of hand-computed products) and a per-requester expected-result queue.
module tb_fpmul_rr_arbiter;
  import fpmul_rr_arbiter_pkg::*;

  localparam int LAT = MUL_LAT_DEF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpmul_rr_arbiter_if bus ();

  fpmul_rr_arbiter #(.MUL_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Hand-computed IEEE single products; unlisted pairs get an arbitrary marker.
  function automatic logic [FP_W-1:0] fp_mul_ref(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
    case ({a, b})
      {32'h3FC00000, 32'h40000000}: return 32'h40400000;
      {32'h40000000, 32'h40000000}: return 32'h40800000;
      {32'hBF800000, 32'h40400000}: return 32'hC0400000;
      {32'h3F800000, 32'h3F800000}: return 32'h3F800000;
      {32'h3F800000, 32'h40000000}: return 32'h40000000;
      {32'h40400000, 32'h40000000}: return 32'h40C00000;
      {32'h40800000, 32'h40000000}: return 32'h41000000;
      {32'h3FC00000, 32'h3FC00000}: return 32'h40100000;
      {32'h7FC00000, 32'h3F800000}: return 32'h7FC00000;
      {32'h7F800000, 32'h40000000}: return 32'h7F800000;
      {32'h00000001, 32'h3F800000}: return 32'h00000001;
      default:                      return a ^ b;
    endcase
  endfunction

  // Stand-in FPmul: FP_Z reflects FP_A/FP_B sampled LAT edges earlier.
  logic [FP_W-1:0] mul_pipe [LAT];
  always @(posedge clk) begin
    mul_pipe[0] <= fp_mul_ref(bus.FP_A, bus.FP_B);
    for (int i = 1; i < LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
  end
  assign bus.FP_Z = mul_pipe[LAT-1];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // ---------------- scoreboard ----------------
  logic [FP_W-1:0] exp0_q[$];
  logic [FP_W-1:0] exp1_q[$];
  int              arr0_q[$];
  int              arr1_q[$];
  int              grant_q[$];
  int              res0_cnt = 0;
  int              res1_cnt = 0;
  logic [FP_W-1:0] exp_fp_a = '0;
  logic [FP_W-1:0] exp_fp_b = '0;
  logic [FP_W-1:0] nxt_fp_a = '0;
  logic [FP_W-1:0] nxt_fp_b = '0;
  int              fp_upd   = -1;

  function automatic logic busy_model(input int now);
    logic b;
    b = 1'b0;
    foreach (arr0_q[i]) if (arr0_q[i] - LAT - 1 <= now && now < arr0_q[i]) b = 1'b1;
    foreach (arr1_q[i]) if (arr1_q[i] - LAT - 1 <= now && now < arr1_q[i]) b = 1'b1;
    return b;
  endfunction

  // Sampled mid-cycle: outputs reflect the last edge, inputs the next one.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (rst) begin
        check("ready0_in_reset", bus.req0_ready, 0);
        check("ready1_in_reset", bus.req1_ready, 0);
        exp0_q.delete(); exp1_q.delete(); arr0_q.delete(); arr1_q.delete();
        nxt_fp_a = '0; nxt_fp_b = '0; fp_upd = cyc + 1;
      end else begin
        if (cyc == fp_upd) begin
          exp_fp_a = nxt_fp_a;
          exp_fp_b = nxt_fp_b;
        end
        check("fp_a", bus.FP_A, exp_fp_a);
        check("fp_b", bus.FP_B, exp_fp_b);
        check("busy", bus.busy, busy_model(cyc));
        check("ready_onehot", bus.req0_ready & bus.req1_ready, 0);

        if (bus.res0_valid) begin
          res0_cnt++;
          check("res0_expected", exp0_q.size() != 0, 1);
          if (exp0_q.size() != 0) begin
            check("res0_z", bus.res0_z, exp0_q.pop_front());
            check("res0_cycle", cyc, arr0_q.pop_front());
          end
        end else if (arr0_q.size() != 0 && arr0_q[0] <= cyc) begin
          check("res0_due", bus.res0_valid, 1);
          void'(exp0_q.pop_front()); void'(arr0_q.pop_front());
        end
        if (bus.res1_valid) begin
          res1_cnt++;
          check("res1_expected", exp1_q.size() != 0, 1);
          if (exp1_q.size() != 0) begin
            check("res1_z", bus.res1_z, exp1_q.pop_front());
            check("res1_cycle", cyc, arr1_q.pop_front());
          end
        end else if (arr1_q.size() != 0 && arr1_q[0] <= cyc) begin
          check("res1_due", bus.res1_valid, 1);
          void'(exp1_q.pop_front()); void'(arr1_q.pop_front());
        end

        if (bus.req0_valid && bus.req0_ready) begin
          exp0_q.push_back(fp_mul_ref(bus.req0_a, bus.req0_b));
          arr0_q.push_back(cyc + LAT + 2);
          grant_q.push_back(0);
          nxt_fp_a = bus.req0_a; nxt_fp_b = bus.req0_b; fp_upd = cyc + 1;
        end
        if (bus.req1_valid && bus.req1_ready) begin
          exp1_q.push_back(fp_mul_ref(bus.req1_a, bus.req1_b));
          arr1_q.push_back(cyc + LAT + 2);
          grant_q.push_back(1);
          nxt_fp_a = bus.req1_a; nxt_fp_b = bus.req1_b; fp_upd = cyc + 1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic v, input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  // Presents one pair and returns just after its accept edge.
  task automatic send(input int id, input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
    logic got = 1'b0;
    drive(id, 1'b1, a, b);
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = (id == 0) ? bus.req0_ready : bus.req1_ready;
    end
    check("send_accepted", got, 1);
    tick();
    drive(id, 1'b0, a, b);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp0_q.size() + exp1_q.size()) != 0 && n < 50) begin
      tick();
      n++;
    end
    check("drain_done", exp0_q.size() + exp1_q.size(), 0);
    repeat (2) tick();
  endtask

  // ---------------- stimulus ----------------
  logic [FP_W-1:0] b2b_a [5] = '{32'h3F800000, 32'h3F800000, 32'h40400000, 32'h40800000, 32'h3FC00000};
  logic [FP_W-1:0] b2b_b [5] = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h40000000, 32'h3FC00000};
  logic [FP_W-1:0] mf_a  [3] = '{32'h7FC00000, 32'h7F800000, 32'h00000001};
  logic [FP_W-1:0] mf_b  [3] = '{32'h3F800000, 32'h40000000, 32'h3F800000};

  initial begin
    int c0, c1;

    // Reset with both requesters asking: nothing may be granted.
    drive(0, 1'b1, 32'h11111111, 32'h22222222);
    drive(1, 1'b1, 32'h33333333, 32'h44444444);
    repeat (3) tick();
    check("rst_fp_a", bus.FP_A, 0);
    check("rst_fp_b", bus.FP_B, 0);
    check("rst_res0_valid", bus.res0_valid, 0);
    check("rst_res1_valid", bus.res1_valid, 0);
    check("rst_res0_z", bus.res0_z, 0);
    check("rst_res1_z", bus.res1_z, 0);
    check("rst_busy", bus.busy, 0);
    rst = 1'b0;
    drive(0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, '0);
    repeat (2) tick();

    // Single request: 1.5 * 2.0, pulse exactly LAT+1 edges after accept.
    send(0, 32'h3FC00000, 32'h40000000);
    for (int k = 1; k <= LAT + 3; k++) begin
      tick();
      check($sformatf("single_res0_valid_e%0d", k), bus.res0_valid, (k == LAT + 1));
      check($sformatf("single_res1_valid_e%0d", k), bus.res1_valid, 0);
      if (k == LAT + 1) check("single_res0_z", bus.res0_z, 32'h40400000);
    end
    drain();

    // Back-to-back on req1: five consecutive grants and pulses.
    grant_q.delete();
    c1 = res1_cnt;
    for (int i = 0; i < 5; i++) begin
      drive(1, 1'b1, b2b_a[i], b2b_b[i]);
      tick();
    end
    drive(1, 1'b0, '0, '0);
    drain();
    check("b2b_grants", grant_q.size(), 5);
    foreach (grant_q[i]) check($sformatf("b2b_grant%0d", i), grant_q[i], 1);
    check("b2b_res1_count", res1_cnt - c1, 5);

    // Contention: both valid for 8 cycles, grants alternate starting at req0.
    grant_q.delete();
    c0 = res0_cnt;
    c1 = res1_cnt;
    drive(0, 1'b1, 32'h40000000, 32'h40000000);
    drive(1, 1'b1, 32'hBF800000, 32'h40400000);
    repeat (8) tick();
    drive(0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, '0);
    drain();
    check("contend_grants", grant_q.size(), 8);
    for (int i = 0; i < grant_q.size() && i < 8; i++)
      check($sformatf("contend_grant%0d", i), grant_q[i], i % 2);
    check("contend_res0_count", res0_cnt - c0, 4);
    check("contend_res1_count", res1_cnt - c1, 4);
    check("contend_res0_z", bus.res0_z, 32'h40800000);
    check("contend_res1_z", bus.res1_z, 32'hC0400000);

    // Reset mid-flight: three issues are dropped, then req0 wins first.
    c0 = res0_cnt;
    c1 = res1_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, mf_a[i], mf_b[i]);
      tick();
    end
    drive(0, 1'b0, '0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mf_busy_after_rst", bus.busy, 0);
    repeat (LAT + 6) tick();
    check("mf_no_res0", res0_cnt - c0, 0);
    check("mf_no_res1", res1_cnt - c1, 0);
    check("mf_busy_idle", bus.busy, 0);
    grant_q.delete();
    drive(0, 1'b1, 32'h40000000, 32'h40000000);
    drive(1, 1'b1, 32'hBF800000, 32'h40400000);
    tick();
    drive(0, 1'b0, '0, '0);
    tick();
    drive(1, 1'b0, '0, '0);
    drain();
    check("mf_grants", grant_q.size(), 2);
    if (grant_q.size() != 0) check("mf_first_grant", grant_q[0], 0);

    // Idle gaps: special encodings pass bit-exact, FP_A/FP_B hold in gaps.
    c0 = res0_cnt;
    c1 = res1_cnt;
    send(0, 32'h7FC00000, 32'h3F800000);
    repeat (2) tick();
    send(1, 32'h7F800000, 32'h40000000);
    repeat (2) tick();
    check("gap_fp_a_hold", bus.FP_A, 32'h7F800000);
    check("gap_fp_b_hold", bus.FP_B, 32'h40000000);
    send(0, 32'h00000001, 32'h3F800000);
    drain();
    check("gap_res0_count", res0_cnt - c0, 2);
    check("gap_res1_count", res1_cnt - c1, 1);
    check("gap_res0_z", bus.res0_z, 32'h00000001);
    check("gap_res1_z", bus.res1_z, 32'h7F800000);
    check("gap_busy_end", bus.busy, 0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
